// File: rtl/ibus_fetch_initiator.sv
// Instruction-fetch initiator for the iBus: issues fetches, pairs in-order responses with their PCs, flushes on redirect.
// Optional build macro IBUS_FETCH_ERROR_STOP_EN stops fetching after a bus error until the next redirect.
module ibus_fetch_initiator #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        iBus_cmd_valid,
    input  logic        iBus_cmd_ready,
    output logic [31:0] iBus_cmd_payload_pc,
    input  logic        iBus_rsp_valid,
    input  logic [31:0] iBus_rsp_payload_inst,
    input  logic        iBus_rsp_payload_error,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic        out_error
);
    localparam int PW = $clog2(DEPTH) + 1;
    localparam int IW = PW - 1;
    localparam int SW = PW + 1;
    localparam logic [SW-1:0] depthLim = SW'(DEPTH);

    logic [31:0]   fetchPc;
    logic [PW-1:0] allocPtr, fillPtr, headPtr, dropCnt;
    logic [31:0]   slotPc     [DEPTH];
    logic [31:0]   slotInst   [DEPTH];
    logic          slotError  [DEPTH];
    logic          slotFilled [DEPTH];

    logic          halted;
    logic [PW-1:0] occupied;
    logic [SW-1:0] usage;
    logic [IW-1:0] allocIdx, fillIdx, headIdx;
    logic          cmdFire, popFire, rspDrop, rspFill;
    logic          unusedPcBits;

    assign allocIdx = allocPtr[IW-1:0];
    assign fillIdx  = fillPtr[IW-1:0];
    assign headIdx  = headPtr[IW-1:0];

    // Capacity uses registered pointers only, so a pop never frees a slot for a same-cycle fire.
    assign occupied = allocPtr - headPtr;
    assign usage    = {1'b0, occupied} + {1'b0, dropCnt};

    assign iBus_cmd_valid      = !reset && !redirect_valid && (usage < depthLim) && !halted;
    assign iBus_cmd_payload_pc = fetchPc;
    assign cmdFire             = iBus_cmd_valid && iBus_cmd_ready;

    assign out_valid = slotFilled[headIdx] && !redirect_valid;
    assign out_pc    = slotPc[headIdx];
    assign out_inst  = slotInst[headIdx];
    assign out_error = slotError[headIdx];
    assign popFire   = out_valid && out_ready;

    assign rspDrop = iBus_rsp_valid && (dropCnt != '0);
    assign rspFill = iBus_rsp_valid && (dropCnt == '0) && !redirect_valid;

    assign unusedPcBits = ^redirect_pc[1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            fetchPc  <= RESET_PC;
            allocPtr <= '0;
            fillPtr  <= '0;
            headPtr  <= '0;
            dropCnt  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                slotPc[i]     <= '0;
                slotInst[i]   <= '0;
                slotError[i]  <= 1'b0;
                slotFilled[i] <= 1'b0;
            end
        end else if (redirect_valid) begin
            // Everything still unanswered becomes a drop credit; a response landing now is one of them.
            fetchPc  <= {redirect_pc[31:2], 2'b00};
            dropCnt  <= dropCnt + (allocPtr - fillPtr) - PW'(iBus_rsp_valid);
            fillPtr  <= allocPtr;
            headPtr  <= allocPtr;
            for (int i = 0; i < DEPTH; i++) begin
                slotFilled[i] <= 1'b0;
            end
        end else begin
            if (cmdFire) begin
                slotPc[allocIdx]     <= fetchPc;
                slotFilled[allocIdx] <= 1'b0;
                allocPtr             <= allocPtr + PW'(1);
                fetchPc              <= fetchPc + 32'd4;
            end
            if (rspDrop) begin
                dropCnt <= dropCnt - PW'(1);
            end
            if (rspFill) begin
                slotInst[fillIdx]   <= iBus_rsp_payload_inst;
                slotError[fillIdx]  <= iBus_rsp_payload_error;
                slotFilled[fillIdx] <= 1'b1;
                fillPtr             <= fillPtr + PW'(1);
            end
            if (popFire) begin
                slotFilled[headIdx] <= 1'b0;
                headPtr             <= headPtr + PW'(1);
            end
        end
    end

`ifdef IBUS_FETCH_ERROR_STOP_EN
    always_ff @(posedge clk) begin
        if (reset || redirect_valid) begin
            halted <= 1'b0;
        end else if (rspFill && iBus_rsp_payload_error) begin
            halted <= 1'b1;
        end
    end
`else
    assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_ibus_fetch_initiator.sv
// Directed table-driven bench for ibus_fetch_initiator (default build), plus a PC-wrap sequence on a second instance.
module tb_ibus_fetch_initiator;
    logic        clk = 1'b0;
    logic        reset;
    logic        cmdValid, cmdReady;
    logic [31:0] cmdPc;
    logic        rspValid, rspError;
    logic [31:0] rspInst;
    logic        redirValid;
    logic [31:0] redirPc;
    logic        outValid, outReady, outError;
    logic [31:0] outPc, outInst;

    logic        wReset, wCmdValid, wCmdReady, wRspValid, wRspError, wRedirValid;
    logic        wOutValid, wOutReady, wOutError;
    logic [31:0] wCmdPc, wRspInst, wRedirPc, wOutPc, wOutInst;

    int nVec  = 0;
    int nCmp  = 0;
    int nMiss = 0;

    always #5 clk = ~clk;

    ibus_fetch_initiator #(.RESET_PC(32'h0000_0080), .DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .iBus_cmd_valid(cmdValid), .iBus_cmd_ready(cmdReady), .iBus_cmd_payload_pc(cmdPc),
        .iBus_rsp_valid(rspValid), .iBus_rsp_payload_inst(rspInst), .iBus_rsp_payload_error(rspError),
        .redirect_valid(redirValid), .redirect_pc(redirPc),
        .out_valid(outValid), .out_ready(outReady), .out_pc(outPc), .out_inst(outInst), .out_error(outError)
    );

    ibus_fetch_initiator #(.RESET_PC(32'hFFFF_FFFC), .DEPTH(4)) wrapDut (
        .clk(clk), .reset(wReset),
        .iBus_cmd_valid(wCmdValid), .iBus_cmd_ready(wCmdReady), .iBus_cmd_payload_pc(wCmdPc),
        .iBus_rsp_valid(wRspValid), .iBus_rsp_payload_inst(wRspInst), .iBus_rsp_payload_error(wRspError),
        .redirect_valid(wRedirValid), .redirect_pc(wRedirPc),
        .out_valid(wOutValid), .out_ready(wOutReady), .out_pc(wOutPc), .out_inst(wOutInst), .out_error(wOutError)
    );

    typedef struct {
        logic        rst, rdy, rv;
        logic [31:0] rinst;
        logic        rerr, redir;
        logic [31:0] rpc;
        logic        ordy;
        logic        eValid;
        logic [31:0] ePc;
        logic        eOutValid, chk;
        logic [31:0] eOutPc, eOutInst;
        logic        eOutErr;
    } vec_t;

    localparam int NV = 35;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic rst, input logic rdy, input logic rv, input logic [31:0] rinst,
                                input logic rerr, input logic redir, input logic [31:0] rpc, input logic ordy,
                                input logic eValid, input logic [31:0] ePc, input logic eOutValid, input logic chk,
                                input logic [31:0] eOutPc, input logic [31:0] eOutInst, input logic eOutErr);
        vec_t v;
        v.rst = rst; v.rdy = rdy; v.rv = rv; v.rinst = rinst; v.rerr = rerr; v.redir = redir; v.rpc = rpc;
        v.ordy = ordy; v.eValid = eValid; v.ePc = ePc; v.eOutValid = eOutValid; v.chk = chk;
        v.eOutPc = eOutPc; v.eOutInst = eOutInst; v.eOutErr = eOutErr;
        return v;
    endfunction

    task automatic cmp(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nMiss++;
            $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    initial begin
        // reset, then streaming with responses two cycles after each fire
        vecs[0]  = mk(1,1,0,32'h0,0,0,32'h0,1,          0,32'h80,  0,1,32'h0,32'h0,0);
        vecs[1]  = mk(0,1,0,32'h0,0,0,32'h0,1,          1,32'h80,  0,0,32'h0,32'h0,0);
        vecs[2]  = mk(0,1,0,32'h0,0,0,32'h0,1,          1,32'h84,  0,0,32'h0,32'h0,0);
        vecs[3]  = mk(0,1,1,32'hC0DE0080,0,0,32'h0,1,   1,32'h88,  0,0,32'h0,32'h0,0);
        vecs[4]  = mk(0,1,1,32'hC0DE0084,0,0,32'h0,1,   1,32'h8C,  1,1,32'h80,32'hC0DE0080,0);
        vecs[5]  = mk(0,1,1,32'hC0DE0088,0,0,32'h0,1,   1,32'h90,  1,1,32'h84,32'hC0DE0084,0);
        vecs[6]  = mk(0,0,1,32'hC0DE008C,0,0,32'h0,1,   1,32'h94,  1,1,32'h88,32'hC0DE0088,0);
        vecs[7]  = mk(0,0,1,32'hC0DE0090,0,0,32'h0,1,   1,32'h94,  1,1,32'h8C,32'hC0DE008C,0);
        vecs[8]  = mk(0,0,0,32'h0,0,0,32'h0,1,          1,32'h94,  1,1,32'h90,32'hC0DE0090,0);
        vecs[9]  = mk(0,0,0,32'h0,0,0,32'h0,1,          1,32'h94,  0,0,32'h0,32'h0,0);
        // decode stalled: exactly four fires, then a single pop frees one slot a cycle later
        vecs[10] = mk(0,1,0,32'h0,0,0,32'h0,0,          1,32'h94,  0,0,32'h0,32'h0,0);
        vecs[11] = mk(0,1,0,32'h0,0,0,32'h0,0,          1,32'h98,  0,0,32'h0,32'h0,0);
        vecs[12] = mk(0,1,1,32'hC0DE0094,0,0,32'h0,0,   1,32'h9C,  0,0,32'h0,32'h0,0);
        vecs[13] = mk(0,1,1,32'hC0DE0098,0,0,32'h0,0,   1,32'hA0,  1,1,32'h94,32'hC0DE0094,0);
        vecs[14] = mk(0,1,1,32'hC0DE009C,0,0,32'h0,0,   0,32'hA4,  1,1,32'h94,32'hC0DE0094,0);
        vecs[15] = mk(0,1,1,32'hC0DE00A0,0,0,32'h0,0,   0,32'hA4,  1,1,32'h94,32'hC0DE0094,0);
        vecs[16] = mk(0,1,0,32'h0,0,0,32'h0,1,          0,32'hA4,  1,1,32'h94,32'hC0DE0094,0);
        vecs[17] = mk(0,1,0,32'h0,0,0,32'h0,0,          1,32'hA4,  1,1,32'h98,32'hC0DE0098,0);
        // redirect voids a pending pop; one outstanding response gets dropped
        vecs[18] = mk(0,1,0,32'h0,0,1,32'h200,1,        0,32'hA8,  0,0,32'h0,32'h0,0);
        vecs[19] = mk(0,0,1,32'hC0DE00A4,0,0,32'h0,1,   1,32'h200, 0,0,32'h0,32'h0,0);
        // three outstanding, redirect with a same-cycle response and ready high
        vecs[20] = mk(0,1,0,32'h0,0,0,32'h0,1,          1,32'h200, 0,0,32'h0,32'h0,0);
        vecs[21] = mk(0,1,0,32'h0,0,0,32'h0,1,          1,32'h204, 0,0,32'h0,32'h0,0);
        vecs[22] = mk(0,1,0,32'h0,0,0,32'h0,1,          1,32'h208, 0,0,32'h0,32'h0,0);
        vecs[23] = mk(0,1,1,32'hC0DE0200,0,1,32'h1002,1,0,32'h20C, 0,0,32'h0,32'h0,0);
        vecs[24] = mk(0,0,1,32'hC0DE0204,0,0,32'h0,1,   1,32'h1000,0,0,32'h0,32'h0,0);
        vecs[25] = mk(0,1,1,32'hC0DE0208,0,0,32'h0,1,   1,32'h1000,0,0,32'h0,32'h0,0);
        vecs[26] = mk(0,0,1,32'hC0DE1000,0,0,32'h0,1,   1,32'h1004,0,0,32'h0,32'h0,0);
        vecs[27] = mk(0,0,0,32'h0,0,0,32'h0,1,          1,32'h1004,1,1,32'h1000,32'hC0DE1000,0);
        // bus error is reported and fetching carries on
        vecs[28] = mk(0,1,0,32'h0,0,0,32'h0,1,          1,32'h1004,0,0,32'h0,32'h0,0);
        vecs[29] = mk(0,0,1,32'hBAD01004,1,0,32'h0,1,   1,32'h1008,0,0,32'h0,32'h0,0);
        vecs[30] = mk(0,1,0,32'h0,0,0,32'h0,1,          1,32'h1008,1,1,32'h1004,32'hBAD01004,1);
        vecs[31] = mk(0,0,1,32'hC0DE1008,0,0,32'h0,1,   1,32'h100C,0,0,32'h0,32'h0,0);
        vecs[32] = mk(0,0,0,32'h0,0,0,32'h0,1,          1,32'h100C,1,1,32'h1008,32'hC0DE1008,0);
        // reset mid-operation
        vecs[33] = mk(1,1,0,32'h0,0,0,32'h0,1,          0,32'h100C,0,0,32'h0,32'h0,0);
        vecs[34] = mk(0,0,0,32'h0,0,0,32'h0,1,          1,32'h80,  0,1,32'h0,32'h0,0);

        reset = 1'b1; cmdReady = 1'b0; rspValid = 1'b0; rspInst = '0; rspError = 1'b0;
        redirValid = 1'b0; redirPc = '0; outReady = 1'b0;
        wReset = 1'b1; wCmdReady = 1'b0; wRspValid = 1'b0; wRspInst = '0; wRspError = 1'b0;
        wRedirValid = 1'b0; wRedirPc = '0; wOutReady = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < NV; i++) begin
            #1;
            reset = vecs[i].rst; cmdReady = vecs[i].rdy; rspValid = vecs[i].rv; rspInst = vecs[i].rinst;
            rspError = vecs[i].rerr; redirValid = vecs[i].redir; redirPc = vecs[i].rpc; outReady = vecs[i].ordy;
            @(negedge clk);
            nVec++;
            cmp("cmd_valid", i, {31'b0, cmdValid}, {31'b0, vecs[i].eValid});
            cmp("cmd_pc",    i, cmdPc, vecs[i].ePc);
            cmp("out_valid", i, {31'b0, outValid}, {31'b0, vecs[i].eOutValid});
            if (vecs[i].chk) begin
                cmp("out_pc",    i, outPc, vecs[i].eOutPc);
                cmp("out_inst",  i, outInst, vecs[i].eOutInst);
                cmp("out_error", i, {31'b0, outError}, {31'b0, vecs[i].eOutErr});
            end
            @(posedge clk);
        end

        // PC wrap from 0xFFFF_FFFC to 0
        #1 wReset = 1'b0; wCmdReady = 1'b1;
        @(negedge clk);
        nVec++;
        cmp("wrap_valid0", 0, {31'b0, wCmdValid}, 32'd1);
        cmp("wrap_pc0",    0, wCmdPc, 32'hFFFF_FFFC);
        @(posedge clk);
        #1 wCmdReady = 1'b0;
        @(negedge clk);
        nVec++;
        cmp("wrap_valid1", 1, {31'b0, wCmdValid}, 32'd1);
        cmp("wrap_pc1",    1, wCmdPc, 32'h0000_0000);
        @(posedge clk);
        #1 wRspValid = 1'b1; wRspInst = 32'h1234_5678;
        @(negedge clk);
        nVec++;
        cmp("wrap_out_valid2", 2, {31'b0, wOutValid}, 32'd0);
        @(posedge clk);
        #1 wRspValid = 1'b0;
        @(negedge clk);
        nVec++;
        cmp("wrap_out_valid3", 3, {31'b0, wOutValid}, 32'd1);
        cmp("wrap_out_pc3",    3, wOutPc, 32'hFFFF_FFFC);
        cmp("wrap_out_inst3",  3, wOutInst, 32'h1234_5678);
        cmp("wrap_out_err3",   3, {31'b0, wOutError}, 32'd0);
        @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
        $finish;
    end
endmodule
